time_of_day_counter: RTL and testbench

TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

---
 rtl/time_of_day_counter.sv | 139 +++++++++++++
 tb/tb_time_of_day_counter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// ---------------------------------------------------------------------------
// time_of_day_counter
//
// Wall-clock time keeper (hours/minutes/seconds) driven from a free-running
// system clock. A programmable divider turns TICK_DIV clock cycles into one
// second tick. Two raw push buttons let the user advance hours and minutes.
// Each button is synchronized and edge-detected, so one press gives at most
// one increment.
//
// Parameters
//   TICK_DIV : clk cycles per one-second tick (>= 2)
//
// Ports
//   clk     in   system clock, rising edge active
//   reset   in   asynchronous, active-high reset of all state
//   run     in   1 = time advances, 0 = hold (divider frozen, buttons live)
//   hour_up in   raw button, rising edge -> hour + 1 (mod 24)
//   min_up  in   raw button, rising edge -> minute + 1 (mod 60)
//   hour    out  current hour   0..23
//   minute  out  current minute 0..59
//   second  out  current second 0..59
//   oneday  out  one-cycle pulse on the tick-driven 23:59:59 -> 00:00:00 rollover
//   tick    out  one-cycle pulse, high in the cycle the new second is shown
// ---------------------------------------------------------------------------
module time_of_day_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       hour_up,
    input  logic       min_up,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       oneday,
    output logic       tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Wrapping increments; the compare against the top value keeps every
    // field inside its legal range without any modulo hardware.
    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q,    div_d;
    logic [4:0]       hour_q,   hour_d;
    logic [5:0]       min_q,    min_d;
    logic [5:0]       sec_q,    sec_d;
    logic             tick_q,   tick_d;
    logic             oneday_q, oneday_d;

    // Button synchronizers: [0] first stage, [1] second stage; *_prev_q holds
    // the previous synchronized level for edge detection.
    logic [1:0]       hu_sync_q;
    logic [1:0]       mu_sync_q;
    logic             hu_prev_q;
    logic             mu_prev_q;

    // -----------------------------------------------------------------------
    // Combinational next-state
    // -----------------------------------------------------------------------
    logic tick_int;
    logic hu_edge;
    logic mu_edge;
    logic sec_carry;
    logic min_carry;

    always_comb begin
        tick_int  = run && (div_q == DIV_LAST);
        hu_edge   = hu_sync_q[1] & ~hu_prev_q;
        mu_edge   = mu_sync_q[1] & ~mu_prev_q;

        // Carries only come from the tick chain; button edges never carry.
        sec_carry = tick_int && (sec_q == 6'd59);
        min_carry = sec_carry && (min_q == 6'd59);

        div_d = div_q;
        if (run) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        sec_d = tick_int ? inc_mod60(sec_q) : sec_q;

        // A button edge coinciding with a carry still moves the field by
        // exactly one: the two requests are OR-ed, not summed.
        min_d  = (mu_edge || sec_carry) ? inc_mod60(min_q)  : min_q;
        hour_d = (hu_edge || min_carry) ? inc_mod24(hour_q) : hour_q;

        tick_d   = tick_int;
        oneday_d = min_carry && (hour_q == 5'd23);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            tick_q    <= 1'b0;
            oneday_q  <= 1'b0;
            hu_sync_q <= '0;
            mu_sync_q <= '0;
            hu_prev_q <= 1'b0;
            mu_prev_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            oneday_q  <= oneday_d;
            hu_sync_q <= {hu_sync_q[0], hour_up};
            mu_sync_q <= {mu_sync_q[0], min_up};
            hu_prev_q <= hu_sync_q[1];
            mu_prev_q <= mu_sync_q[1];
        end
    end

    assign hour   = hour_q;
    assign minute = min_q;
    assign second = sec_q;
    assign tick   = tick_q;
    assign oneday = oneday_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
module tb_time_of_day_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       hour_up = 1'b0;
    logic       min_up = 1'b0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       oneday;
    logic       tick;

    always #5 clk = ~clk;

    time_of_day_counter #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .hour_up (hour_up),
        .min_up  (min_up),
        .hour    (hour),
        .minute  (minute),
        .second  (second),
        .oneday  (oneday),
        .tick    (tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time as h/m/s, a divider phase, and the raw button
    // samples of the last three clock edges (a press is seen two edges after
    // it is sampled and applied on the following edge).
    int mh, mm, ms, mdiv;
    bit etick, eoneday;
    bit hb1, hb2, hb3, mb1, mb2, mb3;

    logic [18:0] got;
    assign got = {hour, minute, second, tick, oneday};

    function automatic logic [18:0] expv();
        return {5'(mh), 6'(mm), 6'(ms), etick, eoneday};
    endfunction

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mdiv = 0;
        etick = 0; eoneday = 0;
        hb1 = 0; hb2 = 0; hb3 = 0; mb1 = 0; mb2 = 0; mb3 = 0;
    endtask

    task automatic model_step(input bit r, input bit hu, input bit mu);
        bit he, me, tk;
        int oh, om, t;
        he = hb2 & ~hb3;
        me = mb2 & ~mb3;
        hb3 = hb2; hb2 = hb1; hb1 = hu;
        mb3 = mb2; mb2 = mb1; mb1 = mu;
        tk = r && (mdiv == TD - 1);
        if (r) mdiv = (mdiv + 1) % TD;
        oh = mh; om = mm;
        eoneday = 0;
        if (tk) begin
            t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            mh = t / 3600;
            mm = (t / 60) % 60;
            ms = t % 60;
            eoneday = (t == 0);
        end
        if (me && mm == om) mm = (mm + 1) % 60;
        if (he && mh == oh) mh = (mh + 1) % 24;
        etick = tk;
    endtask

    task automatic cycle(input bit r, input bit hu, input bit mu);
        @(negedge clk);
        run = r; hour_up = hu; min_up = mu;
        @(posedge clk);
        model_step(r, hu, mu);
        #1;
    endtask

    task automatic apply_reset(input bit hu_hold);
        @(negedge clk);
        reset = 1; run = 0; hour_up = hu_hold; min_up = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic run_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(r, 0, 0);
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        run_cycles(2, 0);
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 1);
            cycle(0, 0, 0);
        end
        run_cycles(2, 0);
    endtask

    task automatic test_reset();
        #2 reset = 1;
        #1;
        checks++; if (hour !== 5'd0) begin errors++; $display("FAIL reset_hour got %0d exp 0", hour); end
        checks++; if (minute !== 6'd0) begin errors++; $display("FAIL reset_min got %0d exp 0", minute); end
        checks++; if (second !== 6'd0) begin errors++; $display("FAIL reset_sec got %0d exp 0", second); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        checks++; if (oneday !== 1'b0) begin errors++; $display("FAIL reset_oneday got %b exp 0", oneday); end
        apply_reset(0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            checks++; if (got !== 19'd0) begin errors++; $display("FAIL reset_first_cycles got %h exp 0", got); end
        end
    endtask

    task automatic test_count();
        int nt, no;
        nt = 0; no = 0;
        apply_reset(0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 0);
            checks++; if (got !== expv()) begin errors++; $display("FAIL count_cycle%0d got %h exp %h", i, got, expv()); end
            nt += tick; no += oneday;
        end
        checks++; if (second !== 6'd10) begin errors++; $display("FAIL count_second got %0d exp 10", second); end
        checks++; if (minute !== 6'd0) begin errors++; $display("FAIL count_minute got %0d exp 0", minute); end
        checks++; if (nt != 10) begin errors++; $display("FAIL count_ticks got %0d exp 10", nt); end
        checks++; if (no != 0) begin errors++; $display("FAIL count_oneday got %0d exp 0", no); end
    endtask

    task automatic test_rollover();
        int nt, no;
        nt = 0; no = 0;
        apply_reset(0);
        run_cycles(58 * TD, 1);
        press_hour(23);
        press_min(59);
        checks++; if ({hour, minute, second} !== {5'd23, 6'd59, 6'd58}) begin
            errors++; $display("FAIL rollover_setup got %0d:%0d:%0d exp 23:59:58", hour, minute, second);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            checks++; if (got !== expv()) begin errors++; $display("FAIL rollover_cycle%0d got %h exp %h", i, got, expv()); end
            nt += tick; no += oneday;
            if (oneday === 1'b1) begin
                checks++; if ({hour, minute, second} !== 17'd0) begin
                    errors++; $display("FAIL rollover_coincident got %0d:%0d:%0d exp 0:0:0", hour, minute, second);
                end
            end
        end
        checks++; if (nt != 2) begin errors++; $display("FAIL rollover_ticks got %0d exp 2", nt); end
        checks++; if (no != 1) begin errors++; $display("FAIL rollover_oneday got %0d exp 1", no); end
    endtask

    task automatic test_hour_wrap();
        press_min(7);
        run_cycles(3 * TD, 1);
        press_hour(23);
        checks++; if ({hour, minute, second} !== {5'd23, 6'd7, 6'd3}) begin
            errors++; $display("FAIL hourwrap_setup got %0d:%0d:%0d exp 23:7:3", hour, minute, second);
        end
        cycle(0, 1, 0);
        checks++; if (hour !== 5'd23) begin errors++; $display("FAIL hourwrap_lat1 got %0d exp 23", hour); end
        cycle(0, 0, 0);
        checks++; if (hour !== 5'd23) begin errors++; $display("FAIL hourwrap_lat2 got %0d exp 23", hour); end
        cycle(0, 0, 0);
        checks++; if ({hour, minute, second, oneday} !== {5'd0, 6'd7, 6'd3, 1'b0}) begin
            errors++; $display("FAIL hourwrap_result got %0d:%0d:%0d od=%b exp 0:7:3 od=0", hour, minute, second, oneday);
        end
        checks++; if (got !== expv()) begin errors++; $display("FAIL hourwrap_model got %h exp %h", got, expv()); end
    endtask

    task automatic test_min_carry();
        apply_reset(0);
        run_cycles(59 * TD, 1);
        press_min(5);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(1, 0, 0);
        checks++; if ({hour, minute, second, tick} !== {5'd0, 6'd6, 6'd0, 1'b1}) begin
            errors++; $display("FAIL mincarry_result got %0d:%0d:%0d tk=%b exp 0:6:0 tk=1", hour, minute, second, tick);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            checks++; if (got !== expv()) begin errors++; $display("FAIL mincarry_after%0d got %h exp %h", i, got, expv()); end
        end
    endtask

    task automatic test_both_buttons();
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        checks++; if ({hour, minute, second} !== {5'd1, 6'd7, 6'd1}) begin
            errors++; $display("FAIL both_buttons got %0d:%0d:%0d exp 1:7:1", hour, minute, second);
        end
    endtask

    task automatic test_hold();
        apply_reset(0);
        run_cycles(6, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            checks++; if (got !== {5'd0, 6'd0, 6'd1, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_cycle%0d got %h exp 00:00:01 quiet", i, got);
            end
        end
        cycle(1, 0, 0);
        checks++; if (tick !== 1'b0 || second !== 6'd1) begin
            errors++; $display("FAIL hold_resume1 got tk=%b s=%0d exp tk=0 s=1", tick, second);
        end
        cycle(1, 0, 0);
        checks++; if (tick !== 1'b1 || second !== 6'd2) begin
            errors++; $display("FAIL hold_resume2 got tk=%b s=%0d exp tk=1 s=2", tick, second);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(0);
        run_cycles(59 * TD, 1);
        press_hour(23);
        press_min(59);
        run_cycles(3, 1);
        checks++; if (got !== {5'd23, 6'd59, 6'd59, 1'b0, 1'b0}) begin
            errors++; $display("FAIL resetmid_setup got %h exp 23:59:59", got);
        end
        @(negedge clk);
        #1 reset = 1;
        #1;
        checks++; if (got !== 19'd0) begin errors++; $display("FAIL resetmid_async got %h exp 0", got); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (got !== 19'd0) begin errors++; $display("FAIL resetmid_held got %h exp 0", got); end
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            checks++; if (got !== expv()) begin errors++; $display("FAIL resetmid_after%0d got %h exp %h", i, got, expv()); end
        end
        checks++; if (tick !== 1'b1 || second !== 6'd1 || oneday !== 1'b0) begin
            errors++; $display("FAIL resetmid_firsttick got tk=%b s=%0d od=%b exp tk=1 s=1 od=0", tick, second, oneday);
        end
    endtask

    task automatic test_button_across_reset();
        apply_reset(1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        run_cycles(2, 0);
        checks++; if (got !== expv()) begin errors++; $display("FAIL heldbtn_model got %h exp %h", got, expv()); end
        checks++; if (hour !== 5'd1) begin errors++; $display("FAIL heldbtn_hour got %0d exp 1", hour); end
    endtask

    task automatic test_random();
        bit r, hu, mu;
        apply_reset(0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            hu = ($urandom_range(0, 5) == 0);
            mu = ($urandom_range(0, 3) == 0);
            cycle(r, hu, mu);
            checks++; if (got !== expv()) begin errors++; $display("FAIL random_cycle%0d got %h exp %h", i, got, expv()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_rollover();
        test_hour_wrap();
        test_min_carry();
        test_both_buttons();
        test_hold();
        test_reset_mid();
        test_button_across_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
